// File: rtl/fp32_to_fixed.sv
// fp32_to_fixed: converts an IEEE-754 single-precision operand into a signed
// fixed-point word with FRAC_BITS fractional bits. Three pipeline stages
// (unpack/classify, align, round/negate/saturate) advance on the falling edge
// of clk_n under one global enable, so a stalled consumer freezes the whole pipe.
module fp32_to_fixed #(
   parameter int OUT_W     = 32,
   parameter int FRAC_BITS = 16
) (
   input  logic             clk_n,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat
);

   // Alignment shift at which the magnitude reaches 2^(OUT_W-1)
   localparam logic signed [10:0] BIG_SH  = 11'(OUT_W - 24);
   localparam logic signed [10:0] ZERO_SH = 11'sd0;
   localparam logic signed [10:0] MIN_RSH = -11'sd25;
   localparam logic [31:0]        MAX_MAG = (32'd1 << (OUT_W - 1)) - 32'd1;
   localparam logic [OUT_W-1:0]   POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]   NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

   // Global advance enable
   logic w_en;

   // Stage 1 combinational results and registers
   logic                w_sign;
   logic [7:0]          w_exp;
   logic [22:0]         w_frac;
   logic signed [10:0]  w_shift;
   logic                w1_nan, w1_inf, w1_zero, w1_ovf, w1_negmin;

   logic                r1_valid, r1_sign, r1_nan, r1_inf, r1_zero, r1_ovf, r1_negmin;
   logic [23:0]         r1_mant;
   logic signed [10:0]  r1_shift;

   // Stage 2 combinational results and registers
   logic [5:0]          w_rsh;
   logic [48:0]         w_ext;
   logic [31:0]         w_lsh;
   logic [31:0]         w2_mag;
   logic                w2_guard, w2_sticky;

   logic                r2_valid, r2_sign, r2_nan, r2_inf, r2_zero, r2_ovf, r2_negmin;
   logic [31:0]         r2_mag;
   logic                r2_guard, r2_sticky;

   // Stage 3 combinational results and output registers
   logic                w_round_up;
   logic [31:0]         w_rnd, w_neg;
   logic [OUT_W-1:0]    w3_data;
   logic                w3_sat;

   logic                r_out_valid;
   logic [OUT_W-1:0]    r_out_data;
   logic                r_out_sat;

   assign w_en      = !r_out_valid || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;

   // S1: split fields, classify, and flag overflow from the exponent alone
   always_comb begin
      w_sign    = in_data[31];
      w_exp     = in_data[30:23];
      w_frac    = in_data[22:0];
      w_shift   = {3'b000, w_exp} - 11'd150 + 11'(FRAC_BITS);
      w1_nan    = 1'b0;
      w1_inf    = 1'b0;
      w1_zero   = 1'b0;
      w1_ovf    = 1'b0;
      w1_negmin = 1'b0;
      case (w_exp)
         8'hFF: begin
            if (w_frac != 23'd0) begin
               w1_nan = 1'b1;
            end else begin
               w1_inf = 1'b1;
            end
         end
         8'h00: begin
            w1_zero = 1'b1;
         end
         default: begin
            // Magnitude >= 2^(OUT_W-1) is known here; only -2^(OUT_W-1) exactly fits
            if (w_shift > BIG_SH) begin
               w1_ovf = 1'b1;
            end else if (w_shift == BIG_SH) begin
               if (w_sign && (w_frac == 23'd0)) begin
                  w1_negmin = 1'b1;
               end else begin
                  w1_ovf = 1'b1;
               end
            end else begin
               w1_ovf = 1'b0;
            end
         end
      endcase
   end

   // S1 register bank: capture the classified operand when the pipe advances
   always_ff @(negedge clk_n or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid  <= 1'b0;
         r1_sign   <= 1'b0;
         r1_nan    <= 1'b0;
         r1_inf    <= 1'b0;
         r1_zero   <= 1'b0;
         r1_ovf    <= 1'b0;
         r1_negmin <= 1'b0;
         r1_mant   <= 24'd0;
         r1_shift  <= 11'sd0;
      end else if (w_en) begin
         r1_valid  <= in_valid;
         r1_sign   <= w_sign;
         r1_nan    <= w1_nan;
         r1_inf    <= w1_inf;
         r1_zero   <= w1_zero;
         r1_ovf    <= w1_ovf;
         r1_negmin <= w1_negmin;
         r1_mant   <= {1'b1, w_frac};
         r1_shift  <= w_shift;
      end
   end

   // S2: align the 24-bit significand; right shifts keep guard and sticky bits
   always_comb begin
      w_rsh     = 6'd0;
      w_ext     = 49'd0;
      w_lsh     = 32'd0;
      w2_mag    = 32'd0;
      w2_guard  = 1'b0;
      w2_sticky = 1'b0;
      if (r1_ovf || r1_negmin || r1_nan || r1_inf || r1_zero) begin
         // Result is fixed by classification; never shift by a wide amount
         w2_mag = 32'd0;
      end else if (r1_shift >= ZERO_SH) begin
         // Non-overflow left shifts are at most OUT_W-25, so nothing is lost
         w_lsh  = {8'd0, r1_mant} << r1_shift[4:0];
         w2_mag = w_lsh;
      end else if (r1_shift < MIN_RSH) begin
         // Value is below a quarter LSB: cannot round up
         w2_mag = 32'd0;
      end else begin
         w_rsh     = 6'(ZERO_SH - r1_shift);
         w_ext     = {r1_mant, 25'd0} >> w_rsh;
         w2_mag    = {8'd0, w_ext[48:25]};
         w2_guard  = w_ext[24];
         w2_sticky = |w_ext[23:0];
      end
   end

   // S2 register bank: hold aligned magnitude and rounding bits
   always_ff @(negedge clk_n or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid  <= 1'b0;
         r2_sign   <= 1'b0;
         r2_nan    <= 1'b0;
         r2_inf    <= 1'b0;
         r2_zero   <= 1'b0;
         r2_ovf    <= 1'b0;
         r2_negmin <= 1'b0;
         r2_mag    <= 32'd0;
         r2_guard  <= 1'b0;
         r2_sticky <= 1'b0;
      end else if (w_en) begin
         r2_valid  <= r1_valid;
         r2_sign   <= r1_sign;
         r2_nan    <= r1_nan;
         r2_inf    <= r1_inf;
         r2_zero   <= r1_zero;
         r2_ovf    <= r1_ovf;
         r2_negmin <= r1_negmin;
         r2_mag    <= w2_mag;
         r2_guard  <= w2_guard;
         r2_sticky <= w2_sticky;
      end
   end

   // S3: round half away from zero, negate, and saturate
   always_comb begin
      // Above half (guard with sticky) and exact tie (guard alone) both round up
      w_round_up = (r2_guard && r2_sticky) || (r2_guard && !r2_sticky);
      w_rnd      = r2_mag + {31'd0, w_round_up};
      w_neg      = 32'd0 - w_rnd;
      w3_data    = {OUT_W{1'b0}};
      w3_sat     = 1'b0;
      if (r2_nan) begin
         w3_data = {OUT_W{1'b0}};
         w3_sat  = 1'b1;
      end else if (r2_inf || r2_ovf) begin
         w3_data = r2_sign ? NEG_SAT : POS_SAT;
         w3_sat  = 1'b1;
      end else if (r2_negmin) begin
         w3_data = NEG_SAT;
         w3_sat  = 1'b0;
      end else if (r2_zero) begin
         w3_data = {OUT_W{1'b0}};
         w3_sat  = 1'b0;
      end else if (!r2_sign) begin
         if (w_rnd > MAX_MAG) begin
            w3_data = POS_SAT;
            w3_sat  = 1'b1;
         end else begin
            w3_data = w_rnd[OUT_W-1:0];
            w3_sat  = 1'b0;
         end
      end else begin
         if (w_rnd > (MAX_MAG + 32'd1)) begin
            w3_data = NEG_SAT;
            w3_sat  = 1'b1;
         end else begin
            w3_data = w_neg[OUT_W-1:0];
            w3_sat  = 1'b0;
         end
      end
   end

   // Output register: load a new result only from a valid S2 entry
   always_ff @(negedge clk_n or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= {OUT_W{1'b0}};
         r_out_sat   <= 1'b0;
      end else if (w_en) begin
         r_out_valid <= r2_valid;
         if (r2_valid) begin
            r_out_data <= w3_data;
            r_out_sat  <= w3_sat;
         end
      end
   end

endmodule

// File: tb/tb_fp32_to_fixed.sv
// tb_fp32_to_fixed: scoreboard bench for fp32_to_fixed (OUT_W=32, FRAC_BITS=16).
// Driver pushes expected results on acceptance; a monitor pops and compares.
module tb_fp32_to_fixed;

   logic        clk_n, rst_n, in_valid, in_ready, out_valid, out_ready, out_sat;
   logic [31:0] in_data, out_data;

   fp32_to_fixed #(.OUT_W(32), .FRAC_BITS(16)) dut (
      .clk_n(clk_n), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat)
   );

   typedef struct {
      logic [31:0] data;
      logic        sat;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          stall_seen = 0;
   logic [31:0] drv_data = 32'd0;
   logic        drv_sat = 1'b0;
   bit          drv_lat = 1'b0;
   bit          last_acc = 1'b0;
   bit          rnd_mode = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = 32'd0;
   logic        prev_sat = 1'b0;

   localparam int NDV = 23;
   localparam logic [31:0] DV_IN [NDV] = '{
      32'h3F800000, 32'hC0200000, 32'h37000000, 32'hB7000000, 32'h36800000,
      32'h47000000, 32'hC7000000, 32'h7F800000, 32'h7FC00000, 32'h80000000,
      32'hFF800000, 32'h00400000, 32'h36FFFFFF, 32'h37C00000, 32'hB7C00000,
      32'h46FFFFFF, 32'hC6FFFFFF, 32'hC7000001, 32'h7F7FFFFF, 32'hFFC00001,
      32'h3F000000, 32'h36000000, 32'h3F7FFFFF };
   localparam logic [31:0] DV_OUT [NDV] = '{
      32'h00010000, 32'hFFFD8000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000,
      32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000000,
      32'h80000000, 32'h00000000, 32'h00000000, 32'h00000002, 32'hFFFFFFFE,
      32'h7FFFFF80, 32'h80000080, 32'h80000000, 32'h7FFFFFFF, 32'h00000000,
      32'h00008000, 32'h00000000, 32'h00010000 };
   localparam bit DV_SAT [NDV] = '{
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
      1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
      1'b0, 1'b0, 1'b0 };

   initial clk_n = 1'b1;
   always #5 clk_n = ~clk_n;

   initial forever begin
      @(negedge clk_n);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: exact integer scaling with add-half-then-truncate rounding
   function automatic logic [32:0] ref_model(input logic [31:0] f);
      int              e;
      int              sh;
      longint unsigned mant;
      longint unsigned mag;
      e = int'(f[30:23]);
      if (e == 255) begin
         if (f[22:0] != 23'd0) return {1'b1, 32'h00000000};
         return f[31] ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
      end
      if (e == 0) return {1'b0, 32'h00000000};
      mant = {40'd0, 1'b1, f[22:0]};
      sh   = e - 150 + 16;
      if (sh >= 0) begin
         if (sh > 30) mag = 64'hFFFF_FFFF_FFFF;
         else         mag = mant << sh;
      end else if (-sh > 60) begin
         mag = 64'd0;
      end else begin
         mag = (mant + (64'd1 << (-sh - 1))) >> (-sh);
      end
      if (!f[31]) begin
         if (mag > 64'h7FFFFFFF) return {1'b1, 32'h7FFFFFFF};
         return {1'b0, mag[31:0]};
      end
      if (mag > 64'h80000000) return {1'b1, 32'h80000000};
      return {1'b0, 32'd0 - mag[31:0]};
   endfunction

   // Monitor: samples at the rising edge, midway between falling edges
   initial begin
      exp_t h;
      forever begin
         @(posedge clk_n);
         if (!rst_n) begin
            prev_stall = 1'b0;
            last_acc   = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, prev_data);
               chk("stall_sat", out_sat, prev_sat);
            end
            if (out_valid && !out_ready) begin
               stall_seen++;
               chk("in_ready_stall", in_ready, 0);
            end
            if (out_valid && !prev_stall && sb.size() > 0 && sb[0].lat)
               chk("latency", cyc, sb[0].acc + 2);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out", out_data, 32'hXXXXXXXX);
               end else begin
                  h = sb.pop_front();
                  chk("data", out_data, h.data);
                  chk("sat", out_sat, h.sat);
               end
            end
            last_acc = in_valid && in_ready;
            if (last_acc) sb.push_back('{drv_data, drv_sat, cyc + 1, drv_lat});
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_sat   = out_sat;
         end
      end
   end

   // Random consumer back-pressure, active only in the random phase
   initial forever begin
      @(negedge clk_n);
      #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 2) != 0);
   end

   task automatic send(input logic [31:0] d, input logic [32:0] exp, input bit lat);
      int w;
      in_data  = d;
      in_valid = 1'b1;
      drv_data = exp[31:0];
      drv_sat  = exp[32];
      drv_lat  = lat;
      w = 0;
      do begin
         @(negedge clk_n);
         #1;
         w++;
      end while (!last_acc && w < 100);
      if (!last_acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk_n);
         #1;
         w++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      logic [31:0] op;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk_n);
      #2;
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Directed vectors, back-to-back, latency checked on each
      for (int i = 0; i < NDV; i++) send(DV_IN[i], {DV_SAT[i], DV_OUT[i]}, 1'b1);
      drain();

      // Eight operands with a five-cycle consumer stall mid-stream
      stall_seen = 0;
      fork
         begin
            for (int k = 1; k <= 8; k++) begin
               op = 32'h3F800000;
               case (k)
                  1: op = 32'h3F800000;
                  2: op = 32'h40000000;
                  3: op = 32'h40400000;
                  4: op = 32'h40800000;
                  5: op = 32'h40A00000;
                  6: op = 32'h40C00000;
                  7: op = 32'h40E00000;
                  default: op = 32'h41000000;
               endcase
               send(op, {1'b0, 32'(k) << 16}, 1'b0);
            end
         end
         begin
            repeat (4) @(negedge clk_n);
            #1;
            out_ready = 1'b0;
            repeat (5) @(negedge clk_n);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_observed", (stall_seen >= 4) ? 1 : 0, 1);

      // Reset with three operands in flight
      out_ready = 1'b0;
      send(32'h40000000, {1'b0, 32'h00020000}, 1'b0);
      send(32'h40400000, {1'b0, 32'h00030000}, 1'b0);
      send(32'h40800000, {1'b0, 32'h00040000}, 1'b0);
      chk("inflight_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_sat", out_sat, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      sb.delete();
      repeat (2) @(negedge clk_n);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(32'h3F800000, {1'b0, 32'h00010000}, 1'b1);
      drain();

      // Random normal operands against the reference model
      rnd_mode = 1'b1;
      for (int i = 0; i < 60; i++) begin
         op = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
         send(op, ref_model(op), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk_n);
            #1;
         end
      end
      rnd_mode = 1'b0;
      @(negedge clk_n);
      #1;
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fp32_to_fixed.md
FP32_TO_FIXED -- requirements
Module: fp32_to_fixed

Interface
REQ-001 SHALL have parameter OUT_W, default 32, the output fixed-point word width (legal 16..32).
REQ-002 SHALL have parameter FRAC_BITS, default 16, the number of fractional bits in the output (legal 0..OUT_W-2).
REQ-003 SHALL have port clk_n, input, 1 bit, clock; all state updates on the falling edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, asserted when in_data holds an operand.
REQ-006 SHALL have port in_ready, output, 1 bit, asserted when the block accepts an operand this edge.
REQ-007 SHALL have port in_data, input, 32 bits, the IEEE-754 single-precision operand.
REQ-008 SHALL have port out_valid, output, 1 bit, asserted when out_data/out_sat hold a result.
REQ-009 SHALL have port out_ready, input, 1 bit, asserted when the consumer takes the result this edge.
REQ-010 SHALL have port out_data, output, OUT_W bits, the two's-complement result scaled by 2^FRAC_BITS.
REQ-011 SHALL have port out_sat, output, 1 bit, flagging a saturated or NaN result for the current out_data.

Function
REQ-012 SHALL count a transfer only on a falling edge where the valid and ready of the same port are both high.
REQ-013 SHALL implement a 3-stage pipeline: S1 unpack/classify, S2 align shift, S3 round/negate/saturate into the output register.
REQ-014 SHALL present a result on out_valid exactly 3 edges after acceptance when out_ready is held high.
REQ-015 SHALL sustain 1 operand per cycle while out_ready is high.
REQ-016 SHALL define a global advance enable = !out_valid || out_ready, drive in_ready = enable, and hold all stages while enable is low.
REQ-017 SHALL let invalid stages (bubbles) carry a cleared valid bit, preserve strict in-order delivery, and never drop or duplicate an operand.
REQ-018 SHALL hold out_data and out_sat stable while out_valid=1 and out_ready=0.
REQ-019 SHALL compute the mathematical value (-1)^s * 1.m * 2^(e-127) * 2^FRAC_BITS for normal inputs (e in 1..254).
REQ-020 SHALL align by shift = e - 150 + FRAC_BITS: left shift when shift >= 0, right shift otherwise.
REQ-021 SHALL round the magnitude to nearest with ties away from zero, using the guard bit and an OR of all lower discarded bits.
REQ-022 SHALL force magnitude 0 when shift < -25 without evaluating rounding.
REQ-023 SHALL negate the rounded magnitude in two's complement when s=1.
REQ-024 SHALL saturate a positive result whose magnitude exceeds 2^(OUT_W-1)-1 to 2^(OUT_W-1)-1 with out_sat=1.
REQ-025 SHALL saturate a negative result whose magnitude exceeds 2^(OUT_W-1) to -2^(OUT_W-1) with out_sat=1; a magnitude of exactly 2^(OUT_W-1) SHALL give -2^(OUT_W-1) with out_sat=0.
REQ-026 SHALL detect overflow from shift width before any shifting, so that no wide shift wraps silently.
REQ-027 SHALL map zero and subnormal inputs (e=0, either sign) to out_data=0 with out_sat=0.
REQ-028 SHALL map +Inf to the positive saturation value and -Inf to the negative saturation value, both with out_sat=1.
REQ-029 SHALL map NaN (e=255, m!=0) to out_data=0 with out_sat=1.

Reset
REQ-030 SHALL, while rst_n=0, clear all stage valid bits, out_valid, out_data and out_sat to 0 immediately, without waiting for a clock edge.
REQ-031 SHALL hold in_ready=1 during and after reset (empty pipeline).
REQ-032 SHALL discard all in-flight operands when reset is asserted mid-operation; the first result after release SHALL come from the first post-reset acceptance.

Verification (OUT_W=32, FRAC_BITS=16)
REQ-033 SHALL cover: 0x3F800000 (1.0) -> 0x00010000, sat=0; 0xC0200000 (-2.5) -> 0xFFFD8000, sat=0; both 3 edges after acceptance.
REQ-034 SHALL cover: 0x37000000 (2^-17, exact half LSB) -> 0x00000001; 0xB7000000 -> 0xFFFFFFFF; 0x36800000 (2^-18) -> 0x00000000.
REQ-035 SHALL cover: 0x47000000 (32768.0) -> 0x7FFFFFFF, sat=1; 0xC7000000 -> 0x80000000, sat=0; 0x7F800000 -> 0x7FFFFFFF, sat=1; 0x7FC00000 -> 0x00000000, sat=1; 0x80000000 -> 0, sat=0.
REQ-036 SHALL cover: 8 back-to-back operands with out_ready low for 5 cycles mid-stream -> in_ready deasserts while out_valid=1 and out_ready=0, all 8 results are delivered in order, and out_data is stable while stalled.
REQ-037 SHALL cover: rst_n pulsed low with 3 operands in flight -> outputs clear immediately, no stale result appears, and the next operand's result follows after 3 edges.
REQ-038 SHALL cover: random normal operands with random in_valid/out_ready against a reference model -> bit-exact out_data and out_sat.
